// File: rtl/dma_pkg.sv
// Shared definitions for the DMA custom instruction: engine states, status bits,
// descriptor field widths and the burst-length helper.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQUEST    = 3'd1,
        INIT_BURST = 3'd2,
        DO_BURST   = 3'd3,
        END_BURST  = 3'd4,
        ABORT      = 3'd5
    } dma_state_t;

    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_ERROR     = 1;
    localparam logic [3:0]  BYTE_ENABLES_ALL = 4'hF;
    localparam int unsigned BLOCK_SIZE_WIDTH = 10;
    localparam int unsigned BURST_SIZE_WIDTH = 8;

    // Words in the next burst: the smaller of what is left and the programmed burst length.
    function automatic logic [BLOCK_SIZE_WIDTH-1:0] burst_words(
        input logic [BLOCK_SIZE_WIDTH-1:0] remaining,
        input logic [BURST_SIZE_WIDTH-1:0] burst_size
    );
        logic [BLOCK_SIZE_WIDTH-1:0] limit;
        limit = BLOCK_SIZE_WIDTH'(burst_size) + BLOCK_SIZE_WIDTH'(1);
        return (remaining < limit) ? remaining : limit;
    endfunction

endpackage

// File: rtl/dma_burst_reader.sv
// DMA bus-master read engine: fetches a block over the shared bus in read bursts
// and writes every received word into scratch-memory port B.
module dma_burst_reader
    import dma_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 9
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      startIn,
    input  logic [31:0]               busStartAddressIn,
    input  logic [MEM_ADDR_WIDTH-1:0] memStartAddressIn,
    input  logic [9:0]                blockSizeIn,
    input  logic [7:0]                burstSizeIn,
    output logic [1:0]                statusOut,
    output logic                      requestTransactionOut,
    input  logic                      transactionGrantedIn,
    output logic                      beginTransactionOut,
    output logic [31:0]               addressDataOut,
    output logic [7:0]                burstSizeOut,
    output logic                      readNotWriteOut,
    output logic [3:0]                byteEnablesOut,
    output logic                      endTransactionOut,
    input  logic [31:0]               addressDataIn,
    input  logic                      dataValidIn,
    input  logic                      endTransactionIn,
    input  logic                      busErrorIn,
    output logic                      memWriteEnableOut,
    output logic [MEM_ADDR_WIDTH-1:0] memAddressOut,
    output logic [31:0]               memDataOut
);

    dma_state_t                  state, state_next;
    logic [31:0]                 bus_addr, bus_addr_next;
    logic [MEM_ADDR_WIDTH-1:0]   mem_addr, mem_addr_next;
    logic [BLOCK_SIZE_WIDTH-1:0] remaining, remaining_next;
    logic [BLOCK_SIZE_WIDTH-1:0] burst_count, burst_count_next;
    logic [BLOCK_SIZE_WIDTH-1:0] words;
    logic                        busy_next, error_next;
    logic                        begin_next, accept;
    logic [31:0]                 address_next;
    logic [7:0]                  burst_size_next;
    logic [MEM_ADDR_WIDTH-1:0]   mem_address_next;
    logic [31:0]                 mem_data_next;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^busStartAddressIn[1:0];

    always_comb begin
        state_next       = state;
        bus_addr_next    = bus_addr;
        mem_addr_next    = mem_addr;
        remaining_next   = remaining;
        burst_count_next = burst_count;
        busy_next        = statusOut[STATUS_BUSY];
        error_next       = statusOut[STATUS_ERROR];
        begin_next       = 1'b0;
        address_next     = '0;
        burst_size_next  = '0;
        accept           = 1'b0;
        mem_address_next = '0;
        mem_data_next    = '0;
        words            = burst_words(remaining, burstSizeIn);

        case (state)
            IDLE: begin
                if (startIn) begin
                    error_next = 1'b0;
                    if (blockSizeIn != '0) begin
                        bus_addr_next  = {busStartAddressIn[31:2], 2'b00};
                        mem_addr_next  = memStartAddressIn;
                        remaining_next = blockSizeIn;
                        busy_next      = 1'b1;
                        state_next     = REQUEST;
                    end
                end
            end
            REQUEST: begin
                // Outputs are registered, so the begin phase is prepared on the grant cycle.
                if (busErrorIn) begin
                    state_next = ABORT;
                end else if (transactionGrantedIn) begin
                    state_next       = INIT_BURST;
                    begin_next       = 1'b1;
                    address_next     = bus_addr;
                    burst_size_next  = 8'(words - BLOCK_SIZE_WIDTH'(1));
                    burst_count_next = words;
                end
            end
            INIT_BURST: begin
                state_next = busErrorIn ? ABORT : DO_BURST;
            end
            DO_BURST: begin
                if (busErrorIn) begin
                    state_next = ABORT;
                end else begin
                    if (dataValidIn && burst_count != '0) begin
                        accept           = 1'b1;
                        mem_address_next = mem_addr;
                        mem_data_next    = addressDataIn;
                        mem_addr_next    = mem_addr + MEM_ADDR_WIDTH'(1);
                        bus_addr_next    = bus_addr + 32'd4;
                        remaining_next   = remaining - BLOCK_SIZE_WIDTH'(1);
                        burst_count_next = burst_count - BLOCK_SIZE_WIDTH'(1);
                    end
                    if (endTransactionIn) begin
                        state_next = END_BURST;
                    end
                end
            end
            END_BURST: begin
                if (remaining != '0) begin
                    state_next = REQUEST;
                end else begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            ABORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // ABORT always exits to IDLE, so this fires exactly once, on entry.
        if (state_next == ABORT) begin
            error_next = 1'b1;
            busy_next  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            bus_addr              <= '0;
            mem_addr              <= '0;
            remaining             <= '0;
            burst_count           <= '0;
            statusOut             <= '0;
            requestTransactionOut <= 1'b0;
            beginTransactionOut   <= 1'b0;
            addressDataOut        <= '0;
            burstSizeOut          <= '0;
            readNotWriteOut       <= 1'b0;
            byteEnablesOut        <= '0;
            endTransactionOut     <= 1'b0;
            memWriteEnableOut     <= 1'b0;
            memAddressOut         <= '0;
            memDataOut            <= '0;
        end else begin
            state                   <= state_next;
            bus_addr                <= bus_addr_next;
            mem_addr                <= mem_addr_next;
            remaining               <= remaining_next;
            burst_count             <= burst_count_next;
            statusOut[STATUS_BUSY]  <= busy_next;
            statusOut[STATUS_ERROR] <= error_next;
            requestTransactionOut   <= (state_next == REQUEST);
            beginTransactionOut     <= begin_next;
            addressDataOut          <= address_next;
            burstSizeOut            <= burst_size_next;
            readNotWriteOut         <= begin_next;
            byteEnablesOut          <= begin_next ? BYTE_ENABLES_ALL : '0;
            endTransactionOut       <= (state_next == ABORT);
            memWriteEnableOut       <= accept;
            memAddressOut           <= mem_address_next;
            memDataOut              <= mem_data_next;
        end
    end

endmodule

// File: tb/tb_dma_burst_reader.sv
// Self-checking bench for dma_burst_reader: a behavioural bus slave drives randomized
// bursts while a descriptor-level model predicts burst headers and scratch-memory writes.
module tb_dma_burst_reader;

    localparam int unsigned MAW = 9;

    logic           clock = 1'b0;
    logic           reset;
    logic           startIn;
    logic [31:0]    busStartAddressIn;
    logic [MAW-1:0] memStartAddressIn;
    logic [9:0]     blockSizeIn;
    logic [7:0]     burstSizeIn;
    logic [1:0]     statusOut;
    logic           requestTransactionOut;
    logic           transactionGrantedIn;
    logic           beginTransactionOut;
    logic [31:0]    addressDataOut;
    logic [7:0]     burstSizeOut;
    logic           readNotWriteOut;
    logic [3:0]     byteEnablesOut;
    logic           endTransactionOut;
    logic [31:0]    addressDataIn;
    logic           dataValidIn;
    logic           endTransactionIn;
    logic           busErrorIn;
    logic           memWriteEnableOut;
    logic [MAW-1:0] memAddressOut;
    logic [31:0]    memDataOut;

    always #5 clock = ~clock;

    dma_burst_reader #(.MEM_ADDR_WIDTH(MAW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .startIn               (startIn),
        .busStartAddressIn     (busStartAddressIn),
        .memStartAddressIn     (memStartAddressIn),
        .blockSizeIn           (blockSizeIn),
        .burstSizeIn           (burstSizeIn),
        .statusOut             (statusOut),
        .requestTransactionOut (requestTransactionOut),
        .transactionGrantedIn  (transactionGrantedIn),
        .beginTransactionOut   (beginTransactionOut),
        .addressDataOut        (addressDataOut),
        .burstSizeOut          (burstSizeOut),
        .readNotWriteOut       (readNotWriteOut),
        .byteEnablesOut        (byteEnablesOut),
        .endTransactionOut     (endTransactionOut),
        .addressDataIn         (addressDataIn),
        .dataValidIn           (dataValidIn),
        .endTransactionIn      (endTransactionIn),
        .busErrorIn            (busErrorIn),
        .memWriteEnableOut     (memWriteEnableOut),
        .memAddressOut         (memAddressOut),
        .memDataOut            (memDataOut)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Bus/memory activity observed on the falling edge.
    logic [31:0]    seen_begin_addr[$];
    logic [7:0]     seen_begin_size[$];
    logic [MAW-1:0] seen_wr_addr[$];
    logic [31:0]    seen_wr_data[$];
    int unsigned    seen_end = 0;
    int unsigned    bus_viol = 0;

    always @(negedge clock) begin
        if (beginTransactionOut) begin
            seen_begin_addr.push_back(addressDataOut);
            seen_begin_size.push_back(burstSizeOut);
            if (!readNotWriteOut || byteEnablesOut != 4'hF) bus_viol++;
        end else if (addressDataOut != '0 || burstSizeOut != '0 || readNotWriteOut || byteEnablesOut != '0) begin
            bus_viol++;
        end
        if (memWriteEnableOut) begin
            seen_wr_addr.push_back(memAddressOut);
            seen_wr_data.push_back(memDataOut);
        end
        if (endTransactionOut) seen_end++;
    end

    logic [31:0] salt;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete transfer: model prediction, slave behaviour and final comparison.
    task automatic run_transfer(input logic [31:0] bus, input logic [MAW-1:0] mem, input int unsigned blk,
                                input int unsigned burst, input int unsigned delay, input int err_at,
                                input bit poke_start, input string name);
        logic [31:0]    exp_begin_addr[$];
        logic [7:0]     exp_begin_size[$];
        logic [MAW-1:0] exp_wr_addr[$];
        logic [31:0]    exp_wr_data[$];
        logic [31:0]    aligned, a;
        int unsigned    rem, w, first, b0, w0, e0, v0, done, held, cnt, n_begin, n_wr;
        bit             aborted;

        b0 = seen_begin_addr.size();
        w0 = seen_wr_addr.size();
        e0 = seen_end;
        v0 = bus_viol;
        salt = $urandom;

        aligned = {bus[31:2], 2'b00};
        a       = aligned;
        rem     = blk;
        first   = 0;
        while (rem != 0) begin
            w = (rem < burst + 1) ? rem : burst + 1;
            if (err_at < 0 || first <= 32'(err_at)) begin
                exp_begin_addr.push_back(a);
                exp_begin_size.push_back(8'(w - 1));
            end
            a     = a + 32'(4 * w);
            rem   = rem - w;
            first = first + w;
        end
        for (int i = 0; i < int'(blk); i++) begin
            if (err_at >= 0 && i >= err_at) break;
            exp_wr_addr.push_back(MAW'(int'(mem) + i));
            exp_wr_data.push_back(word_at(aligned + 32'(4 * i)));
        end

        busStartAddressIn = bus;
        memStartAddressIn = mem;
        blockSizeIn       = 10'(blk);
        burstSizeIn       = 8'(burst);
        startIn           = 1'b1;
        tick();
        startIn           = 1'b0;
        busStartAddressIn = $urandom;
        memStartAddressIn = MAW'($urandom);
        blockSizeIn       = 10'($urandom);
        check({name, "_start_status"}, 32'(statusOut), (blk != 0) ? 32'd1 : 32'd0);
        check({name, "_start_request"}, 32'(requestTransactionOut), (blk != 0) ? 32'd1 : 32'd0);

        done    = 0;
        aborted = 1'b0;
        for (int bi = 0; bi < exp_begin_addr.size() && !aborted; bi++) begin
            cnt = 0;
            while (!requestTransactionOut && cnt < 20) begin
                tick();
                cnt++;
            end
            check({name, "_request"}, 32'(requestTransactionOut), 32'd1);
            held = 0;
            for (int d = 0; d < int'(delay); d++) begin
                if (requestTransactionOut) held++;
                if (poke_start && d == 0) begin
                    startIn           = 1'b1;
                    busStartAddressIn = $urandom;
                    blockSizeIn       = 10'd3;
                end
                tick();
                startIn = 1'b0;
            end
            check({name, "_request_held"}, 32'(held), 32'(delay));
            transactionGrantedIn = 1'b1;
            tick();
            transactionGrantedIn = 1'b0;
            check({name, "_begin_latency"}, 32'(beginTransactionOut), 32'd1);
            tick();
            for (int k = 0; k <= int'(exp_begin_size[bi]); k++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (err_at >= 0 && done == 32'(err_at)) begin
                    busErrorIn       = 1'b1;
                    dataValidIn      = 1'b1;
                    addressDataIn    = $urandom;
                    endTransactionIn = 1'($urandom_range(0, 1));
                    tick();
                    busErrorIn       = 1'b0;
                    dataValidIn      = 1'b0;
                    endTransactionIn = 1'b0;
                    aborted          = 1'b1;
                    break;
                end
                dataValidIn   = 1'b1;
                addressDataIn = word_at(aligned + 32'(4 * done));
                tick();
                dataValidIn = 1'b0;
                done++;
            end
            if (!aborted) begin
                if ($urandom_range(0, 1) == 1) begin
                    dataValidIn   = 1'b1;
                    addressDataIn = 32'hDEAD_BEEF;
                    tick();
                    dataValidIn = 1'b0;
                end
                endTransactionIn = 1'b1;
                tick();
                endTransactionIn = 1'b0;
            end
        end

        if (aborted) begin
            check({name, "_abort_end"}, 32'(endTransactionOut), 32'd1);
            check({name, "_abort_status"}, 32'(statusOut), 32'd2);
            tick();
            tick();
            check({name, "_error_status"}, 32'(statusOut), 32'd2);
        end else begin
            cnt = 0;
            while (statusOut[0] && cnt < 10) begin
                tick();
                cnt++;
            end
            check({name, "_done_status"}, 32'(statusOut), 32'd0);
            tick();
        end
        check({name, "_idle_request"}, 32'(requestTransactionOut), 32'd0);

        n_begin = seen_begin_addr.size() - b0;
        n_wr    = seen_wr_addr.size() - w0;
        check({name, "_n_bursts"}, n_begin, 32'(exp_begin_addr.size()));
        for (int i = 0; i < exp_begin_addr.size() && i < int'(n_begin); i++) begin
            check({name, "_burst_addr"}, seen_begin_addr[b0 + i], exp_begin_addr[i]);
            check({name, "_burst_size"}, 32'(seen_begin_size[b0 + i]), 32'(exp_begin_size[i]));
        end
        check({name, "_n_writes"}, n_wr, 32'(exp_wr_addr.size()));
        for (int i = 0; i < exp_wr_addr.size() && i < int'(n_wr); i++) begin
            check({name, "_wr_addr"}, 32'(seen_wr_addr[w0 + i]), 32'(exp_wr_addr[i]));
            check({name, "_wr_data"}, seen_wr_data[w0 + i], exp_wr_data[i]);
        end
        check({name, "_end_pulses"}, seen_end - e0, aborted ? 32'd1 : 32'd0);
        check({name, "_bus_idle_zero"}, bus_viol - v0, 32'd0);
    endtask

    task automatic reset_mid_burst();
        int unsigned w_at, e_at;
        busStartAddressIn = 32'h0000_4000;
        memStartAddressIn = MAW'(9'h040);
        blockSizeIn       = 10'd8;
        burstSizeIn       = 8'd7;
        startIn           = 1'b1;
        tick();
        startIn              = 1'b0;
        transactionGrantedIn = 1'b1;
        tick();
        transactionGrantedIn = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            dataValidIn   = 1'b1;
            addressDataIn = $urandom;
            tick();
        end
        #3 reset = 1'b0;
        #2;
        check("rst_status", 32'(statusOut), 32'd0);
        check("rst_request", 32'(requestTransactionOut), 32'd0);
        check("rst_begin", 32'(beginTransactionOut), 32'd0);
        check("rst_address", addressDataOut, 32'd0);
        check("rst_mem_we", 32'(memWriteEnableOut), 32'd0);
        check("rst_mem_data", memDataOut, 32'd0);
        check("rst_end", 32'(endTransactionOut), 32'd0);
        w_at = seen_wr_addr.size();
        e_at = seen_end;
        dataValidIn = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_release_status", 32'(statusOut), 32'd0);
        check("rst_release_request", 32'(requestTransactionOut), 32'd0);
        repeat (3) tick();
        check("rst_no_writes", seen_wr_addr.size() - w_at, 32'd0);
        check("rst_no_end", seen_end - e_at, 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_at;
        int unsigned blk;
        reset                = 1'b1;
        startIn              = 1'b0;
        busStartAddressIn    = '0;
        memStartAddressIn    = '0;
        blockSizeIn          = '0;
        burstSizeIn          = '0;
        transactionGrantedIn = 1'b0;
        addressDataIn        = '0;
        dataValidIn          = 1'b0;
        endTransactionIn     = 1'b0;
        busErrorIn           = 1'b0;
        #2 reset = 1'b0;
        repeat (3) tick();
        check("reset_status", 32'(statusOut), 32'd0);
        check("reset_request", 32'(requestTransactionOut), 32'd0);
        check("reset_begin", 32'(beginTransactionOut), 32'd0);
        check("reset_mem_we", 32'(memWriteEnableOut), 32'd0);
        check("reset_end", 32'(endTransactionOut), 32'd0);
        reset = 1'b1;
        tick();

        run_transfer(32'h0000_1000, MAW'(9'h010), 8, 3, 0, -1, 1'b0, "blk8");
        run_transfer(32'h0000_1000, MAW'(9'h010), 5, 3, 0, -1, 1'b0, "blk5");
        run_transfer(32'h0000_2000, MAW'(9'h1FE), 4, 7, 0, -1, 1'b0, "memwrap");
        run_transfer(32'h0000_3000, MAW'(9'h020), 8, 3, 1, 2, 1'b0, "buserr");
        run_transfer(32'h0000_5000, MAW'(9'h030), 0, 3, 0, -1, 1'b0, "blk0");
        run_transfer(32'h0000_3006, MAW'(9'h100), 6, 1, 10, -1, 1'b1, "grant10");
        run_transfer(32'hFFFF_FFF8, MAW'(9'h0A0), 4, 7, 0, -1, 1'b0, "buswrap");
        run_transfer(32'h0001_0000, MAW'(9'h000), 300, 255, 2, -1, 1'b0, "burst256");
        reset_mid_burst();

        for (int t = 0; t < 12; t++) begin
            blk    = $urandom_range(1, 40);
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, blk - 1)) : -1;
            run_transfer($urandom, MAW'($urandom), blk, $urandom_range(0, 15),
                         $urandom_range(0, 3), err_at, 1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_burst_reader.md
# dma_burst_reader

Bus-master engine of the DMA custom instruction. It takes a transfer descriptor from the DMA register file: bus start address, memory start address, block size and burst size. It fetches the block from the shared bus using read bursts and writes each received word into port B of the DMA scratch memory. It reports busy/error status back to the register file.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 9, scratch-memory word-address width; addresses wrap modulo 2^MEM_ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- startIn  in  1  one-cycle pulse; begins a transfer using the descriptor inputs.
- busStartAddressIn  in  32  byte address of the first word; bits [1:0] ignored.
- memStartAddressIn  in  MEM_ADDR_WIDTH  first scratch-memory word address.
- blockSizeIn  in  10  words to transfer (0..1023).
- burstSizeIn  in  8  words per burst minus one (0..255).
- statusOut  out  2  bit0 busy, bit1 error.
- requestTransactionOut  out  1  bus request.
- transactionGrantedIn  in  1  bus grant.
- beginTransactionOut  out  1  one-cycle transaction start.
- addressDataOut  out  32  burst start address during beginTransactionOut, else 0.
- burstSizeOut  out  8  words in this burst minus one, valid with beginTransactionOut, else 0.
- readNotWriteOut  out  1  1 with beginTransactionOut, else 0.
- byteEnablesOut  out  4  4'hF with beginTransactionOut, else 0.
- endTransactionOut  out  1  master-side end (error abort only).
- addressDataIn  in  32  read data.
- dataValidIn  in  1  addressDataIn carries a valid word.
- endTransactionIn  in  1  slave ends burst.
- busErrorIn  in  1  slave error.
- memWriteEnableOut  out  1  scratch-memory write strobe.
- memAddressOut  out  MEM_ADDR_WIDTH  write address.
- memDataOut  out  32  write data.

## Operation
- All outputs are registered. All bus outputs drive 0 when inactive, because the bus is OR-combined.
- States: IDLE, REQUEST, INIT_BURST, DO_BURST, END_BURST, ABORT.
- IDLE + startIn with blockSizeIn≠0:
  - latch busAddr = {busStartAddressIn[31:2],2'b00}, memAddr, remaining = blockSizeIn;
  - clear error, set busy;
  - go to REQUEST.
- IDLE + startIn with blockSizeIn=0: no bus activity; error cleared; busy stays 0.
- startIn outside IDLE is ignored.
- REQUEST: requestTransactionOut=1 until transactionGrantedIn, then INIT_BURST.
- INIT_BURST: one cycle of beginTransactionOut=1 and addressDataOut=busAddr.
  - burstWords = min(remaining, burstSizeIn+1); burstSizeOut = burstWords-1.
  - burstSizeIn is sampled here, not at start.
  - Next state: DO_BURST.
- DO_BURST, on each dataValidIn while burstCount≠0:
  - write the word to memAddr;
  - memAddr+1 (wraps); busAddr+4 (wraps at 2^32); remaining-1; burstCount-1.
  - dataValidIn with burstCount=0 is ignored.
- DO_BURST + endTransactionIn → END_BURST, including a short burst (the remainder stays pending).
- END_BURST:
  - remaining≠0 → REQUEST;
  - remaining=0 → IDLE, busy cleared.
- busErrorIn in REQUEST/INIT_BURST/DO_BURST:
  - go to ABORT;
  - the word in the same cycle is discarded.
- ABORT:
  - endTransactionOut=1 for one cycle;
  - error set, busy cleared;
  - go to IDLE.
- busErrorIn and endTransactionIn in the same cycle: error wins.

## Timing
- Reset (asynchronous, active-low) values:
  - state IDLE;
  - statusOut=2'b00;
  - every bus and memory output 0.
- startIn at cycle t:
  - busy=1 and requestTransactionOut=1 at t+1;
  - grant sampled at t+k → beginTransactionOut at t+k+1.
- memWriteEnableOut/memAddressOut/memDataOut are asserted the cycle after the accepted dataValidIn. Writes are back-to-back, one per valid word.
- Last-word handling:
  - busy falls the cycle after END_BURST;
  - the final memory write completes no later than that cycle.
- Reset mid-transfer aborts immediately. No endTransactionOut is issued and no memory write is pending after reset.

## Structure
- Shared package dma_pkg holds:
  - state encoding (3-bit localparams/enum);
  - status bit indices;
  - BYTE_ENABLES_ALL=4'hF;
  - descriptor field widths (10-bit block, 8-bit burst).
- No sub-module; burst-length min() and counters are inline. The DMA register file instantiates this block and connects scratch-memory port B.

## Test plan
- Block 8, burst 3, bus 0x0000_1000, mem 0x010, immediate grant:
  - two bursts with begin at address 0x1000 then 0x1010, burstSizeOut=3 each;
  - writes at 0x010..0x017 with the matching data;
  - status 00 afterwards.
- Block 5, burst 3:
  - burstSizeOut 3 then 0, second address 0x1010;
  - 5 writes.
- mem 0x1FE, block 4: writes at 0x1FE, 0x1FF, 0x000, 0x001.
- busErrorIn after 2 words of a 4-word burst:
  - endTransactionOut one cycle, status=2'b10, exactly 2 writes;
  - next startIn clears error.
- Edge cases for start and grant:
  - grant delayed 10 cycles: request held for all 10;
  - startIn pulses while busy: ignored;
  - block 0: no request, status 00.
- reset low mid-DO_BURST: all outputs 0 asynchronously; IDLE after release.
